// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers for the iterative cipher and inverse-cipher blocks.
package aes_pkg;

   localparam int Nb = 4;

   // Forward S-box, byte 0x00 in the MSBs.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = '0;
      aa = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational 8-bit AES forward S-box.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] in,
   output logic [7:0] out
);

   assign out = sbox(in);

endmodule

// File: rtl/aes_encrypt.sv
// Iterative AES encryptor: whitening step, then one round per enabled clock, then hold.
module aes_encrypt
   import aes_pkg::*;
#(
   parameter int Nk = 4,
   parameter int Nr = 10
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [127:0]            in,
   input  logic [128*(Nr+1)-1:0]   keys,
   output logic [127:0]            out
);

   localparam int RCW = $clog2(Nr + 2);
   localparam logic [RCW-1:0] RC_LAST = RCW'(Nr);
   localparam logic [RCW-1:0] RC_DONE = RCW'(Nr + 1);

   if (Nr != Nk + 6) begin : g_cfg_err
      $error("aes_encrypt: Nr must equal Nk+6");
   end

   logic [RCW-1:0] rc;
   logic [7:0]     sb [16];
   logic [7:0]     sr [16];
   logic [7:0]     mc [16];
   logic [127:0]   rkey [Nr+1];
   logic [127:0]   rk;
   logic [127:0]   round_out;

   for (genvar i = 0; i <= Nr; i++) begin : g_rk
      assign rkey[i] = keys[128*(Nr+1-i)-1 -: 128];
   end

   for (genvar i = 0; i < 16; i++) begin : g_sbox
      aes_sbox u_sbox (
         .in  (out[127-8*i -: 8]),
         .out (sb[i])
      );
   end

   // rc = Nr+1 selects no key; the result is unused once done.
   always_comb begin
      rk = '0;
      for (int unsigned i = 0; i < Nr + 1; i++)
         if (rc == RCW'(i)) rk = rkey[i];
   end

   always_comb begin
      sr        = '{default: '0};
      mc        = '{default: '0};
      round_out = '0;
      for (int unsigned r = 0; r < 4; r++)
         for (int unsigned c = 0; c < Nb; c++)
            sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
      for (int unsigned c = 0; c < Nb; c++) begin
         mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
         mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
      end
      for (int unsigned i = 0; i < 16; i++)
         round_out[127-8*i -: 8] = ((rc == RC_LAST) ? sr[i] : mc[i]) ^ rk[127-8*i -: 8];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out <= '0;
         rc  <= '0;
      end else if (enable && rc != RC_DONE) begin
         out <= (rc == '0) ? (in ^ rk) : round_out;
         rc  <= rc + 1'b1;
      end
   end

endmodule

// File: tb/tb_aes_encrypt.sv
// Self-checking bench for aes_encrypt (AES-128/192/256 instances side by side) against a byte-level AES model.
module tb_aes_encrypt;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          enable;
   logic [127:0]  pt;
   logic [1919:0] sch [3];
   logic [1407:0] k128;
   logic [1663:0] k192;
   logic [1919:0] k256;
   logic [127:0]  out128, out192, out256;
   logic [127:0]  outs [3];

   assign k128 = sch[0][1919 -: 1408];
   assign k192 = sch[1][1919 -: 1664];
   assign k256 = sch[2];
   assign outs[0] = out128;
   assign outs[1] = out192;
   assign outs[2] = out256;

   aes_encrypt #(.Nk(4), .Nr(10)) u128 (.clk(clk), .reset(reset), .enable(enable), .in(pt), .keys(k128), .out(out128));
   aes_encrypt #(.Nk(6), .Nr(12)) u192 (.clk(clk), .reset(reset), .enable(enable), .in(pt), .keys(k192), .out(out192));
   aes_encrypt #(.Nk(8), .Nr(14)) u256 (.clk(clk), .reset(reset), .enable(enable), .in(pt), .keys(k256), .out(out256));

   int checks   = 0;
   int failures = 0;

   int           nr_of [3] = '{10, 12, 14};
   int           nk_of [3] = '{4, 6, 8};
   logic [127:0] exp_st [3];
   int           cnt [3];
   logic [7:0]   sbox_m [256];

   localparam logic [127:0] FIPS_PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192     = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256     = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] R0_128    = 128'h00102030405060708090a0b0c0d0e0f0;
   localparam logic [127:0] R1_128    = 128'h89d810e8855ace682d1843d8cb128fe4;

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [15:0] d;
      d = {x, x} << n;
      return d[15:8];
   endfunction

   // S-box from its definition: GF(2^8) inverse followed by the affine map.
   task automatic build_sbox();
      for (int b = 0; b < 256; b++) begin
         logic [7:0] inv, bb;
         bb  = 8'(b);
         inv = 8'h01;
         for (int n = 0; n < 254; n++) inv = gm(inv, bb);
         if (b == 0) inv = 8'h00;
         sbox_m[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subword(input logic [31:0] w);
      return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
   endfunction

   function automatic logic [1919:0] expand(input logic [255:0] key, input int nk, input int nr);
      logic [31:0]   w [60];
      logic [31:0]   t;
      logic [7:0]    rcon;
      logic [1919:0] res;
      rcon = 8'h01;
      res  = '0;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t    = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
            rcon = gm(rcon, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            t = subword(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int i = 0; i < 4*(nr+1); i++) res[1919-32*i -: 32] = w[i];
      return res;
   endfunction

   // One cipher step on a byte view of the state: step 0 whitening, step nr the final round.
   function automatic logic [127:0] m_step(input logic [127:0] st, input logic [1919:0] ks,
                                           input int nr, input int step);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [127:0] rk, res;
      rk = ks[1919-128*step -: 128];
      if (step == 0) return st ^ rk;
      for (int i = 0; i < 16; i++) s[i] = sbox_m[st[127-8*i -: 8]];
      for (int i = 0; i < 16; i++) t[i] = s[(i % 4) + 4*(((i / 4) + (i % 4)) % 4)];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (step == nr) s[4*c+r] = t[4*c+r];
            else s[4*c+r] = gm(8'h02, t[4*c+r]) ^ gm(8'h03, t[4*c+(r+1)%4])
                          ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res ^ rk;
   endfunction

   task automatic load_key(input logic [255:0] key);
      for (int k = 0; k < 3; k++) sch[k] = expand(key, nk_of[k], nr_of[k]);
   endtask

   task automatic model_clear();
      for (int k = 0; k < 3; k++) begin
         exp_st[k] = '0;
         cnt[k]    = 0;
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      enable = 1'b0;
      reset  = 1'b1;
      model_clear();
      #2 reset = 1'b0;
   endtask

   task automatic tick(input logic en);
      @(negedge clk);
      enable = en;
      @(posedge clk);
      if (en && !reset)
         for (int k = 0; k < 3; k++)
            if (cnt[k] <= nr_of[k]) begin
               exp_st[k] = m_step((cnt[k] == 0) ? pt : exp_st[k], sch[k], nr_of[k], cnt[k]);
               cnt[k]++;
            end
      #1;
   endtask

   task automatic test_reset();
      pt = FIPS_PT;
      load_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0});
      @(negedge clk);
      reset  = 1'b1;
      enable = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (outs[k] !== 128'h0) begin
            failures++;
            $display("FAIL reset_out[%0d]: got %h expected %h", k, outs[k], 128'h0);
         end
      end
      @(posedge clk);
      #1;
      checks++;
      if (out128 !== 128'h0) begin
         failures++;
         $display("FAIL reset_wins_over_enable: got %h expected %h", out128, 128'h0);
      end
      reset  = 1'b0;
      enable = 1'b0;
   endtask

   task automatic test_fips_vectors();
      pt     = FIPS_PT;
      sch[0] = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
      sch[1] = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6, 12);
      sch[2] = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
      apply_reset();
      for (int e = 1; e <= 16; e++) begin
         tick(1'b1);
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (outs[k] !== exp_st[k]) begin
               failures++;
               $display("FAIL fips_model[%0d] edge %0d: got %h expected %h", k, e, outs[k], exp_st[k]);
            end
         end
         if (e == 1) begin
            checks++;
            if (out128 !== R0_128) begin
               failures++;
               $display("FAIL aes128_edge1: got %h expected %h", out128, R0_128);
            end
         end
         if (e == 2) begin
            checks++;
            if (out128 !== R1_128) begin
               failures++;
               $display("FAIL aes128_edge2: got %h expected %h", out128, R1_128);
            end
         end
         if (e >= 11) begin
            checks++;
            if (out128 !== CT128) begin
               failures++;
               $display("FAIL aes128_ct edge %0d: got %h expected %h", e, out128, CT128);
            end
         end
         if (e >= 13) begin
            checks++;
            if (out192 !== CT192) begin
               failures++;
               $display("FAIL aes192_ct edge %0d: got %h expected %h", e, out192, CT192);
            end
         end
         if (e == 15) begin
            checks++;
            if (out256 !== CT256) begin
               failures++;
               $display("FAIL aes256_ct: got %h expected %h", out256, CT256);
            end
         end
      end
   endtask

   task automatic test_pause();
      logic [127:0] snap;
      apply_reset();
      for (int e = 0; e < 4; e++) tick(1'b1);
      snap = exp_st[0];
      for (int e = 0; e < 3; e++) begin
         tick(1'b0);
         checks++;
         if (out128 !== snap) begin
            failures++;
            $display("FAIL pause_frozen cycle %0d: got %h expected %h", e, out128, snap);
         end
      end
      for (int e = 0; e < 7; e++) begin
         tick(1'b1);
         if (e == 5) begin
            checks++;
            if (out128 === CT128 || out128 !== exp_st[0]) begin
               failures++;
               $display("FAIL pause_not_early: got %h expected %h", out128, exp_st[0]);
            end
         end
      end
      checks++;
      if (out128 !== CT128) begin
         failures++;
         $display("FAIL pause_result: got %h expected %h", out128, CT128);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      for (int e = 0; e < 6; e++) tick(1'b1);
      #1 reset = 1'b1;
      model_clear();
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (outs[k] !== 128'h0) begin
            failures++;
            $display("FAIL async_reset[%0d]: got %h expected %h", k, outs[k], 128'h0);
         end
      end
      #1 reset = 1'b0;
      for (int e = 0; e < 11; e++) tick(1'b1);
      checks++;
      if (out128 !== CT128) begin
         failures++;
         $display("FAIL rerun_after_reset: got %h expected %h", out128, CT128);
      end
   endtask

   task automatic test_random();
      logic [255:0] key;
      for (int it = 0; it < 6; it++) begin
         for (int j = 0; j < 8; j++) key[32*j +: 32] = $urandom;
         pt = {$urandom, $urandom, $urandom, $urandom};
         load_key(key);
         apply_reset();
         for (int e = 0; e < 24; e++) begin
            tick(($urandom % 4) != 0);
            if (($urandom % 3) == 0) pt = {$urandom, $urandom, $urandom, $urandom};
            for (int k = 0; k < 3; k++) begin
               checks++;
               if (outs[k] !== exp_st[k]) begin
                  failures++;
                  $display("FAIL random[%0d] iter %0d cyc %0d: got %h expected %h",
                           k, it, e, outs[k], exp_st[k]);
               end
            end
         end
      end
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      pt     = '0;
      for (int k = 0; k < 3; k++) sch[k] = '0;
      build_sbox();
      model_clear();
      test_reset();
      test_fips_vectors();
      test_pause();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/aes_encrypt.md
# aes_encrypt

Iterative AES block encryptor, parameterised for AES-128/192/256, one round per enabled clock. Sits behind the key-expansion block, which supplies the full round-key schedule as one flat bus. Drives the intermediate/final ciphertext state to the display/LED top level. Also feeds the matching iterative decryptor, which is specified separately.

## Interface
- Nk, default 4: key length in 32-bit words (4/6/8); informational only, not used in datapath.
- Nr, default 10: number of rounds (10/12/14).
- clk  input  1: rising-edge clock.
- reset  input  1: asynchronous, active-high.
- enable  input  1: advance one step on this clock edge when high.
- in  input  128: plaintext block; bits [127:120] = FIPS-197 byte 0, column-major.
- keys  input  128*(Nr+1): round-key schedule; round key i at bits [128*(Nr+1-i)-1 -: 128], so key 0 sits in the MSBs.
- out  output  128: current state register, same byte order as in.

## Operation
- Internal round counter rc, range 0..Nr+1, plus 128-bit state register driving out.
- Step taken on each rising edge with enable=1 and reset=0:
  - rc=0: state <= in XOR key0; rc <= 1.
  - rc=1..Nr-1: state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), key rc); rc <= rc+1.
  - rc=Nr: final round, no MixColumns; state <= AddRoundKey(ShiftRows(SubBytes(state)), key Nr); rc <= Nr+1.
  - rc=Nr+1: done; state and rc hold; further enables ignored.
- enable=0: state and rc hold.
- in is consumed only at the rc=0 step. Changes to in or keys after that step have no effect until the next reset, except that later steps read keys live.
- SubBytes: FIPS-197 S-box. MixColumns: GF(2^8) with polynomial 0x11B; xtime = shift-left with conditional XOR 0x1B.
- All operations are combinational from the state register. Exactly one round of logic sits between registers.

## Timing
- Reset asserted: out=0 and rc=0 immediately, without waiting for a clock edge. Reset mid-operation aborts the computation. The next run starts from rc=0 after release.
- Latency: ciphertext appears on out after Nr+1 enabled edges following reset release (11/13/15).
- After k enabled edges (1≤k≤Nr+1), out holds the state after round k-1. The top level displays it live.
- Reset and enable high together: reset wins.
- No handshake. The caller counts enabled cycles to know when the result is valid.

## Structure
- Shared package aes_pkg: Nb=4 constant, S-box lookup function, xtime and gmul helper functions.
- Sub-module aes_sbox: 8-bit combinational S-box, instantiated 16×.
- ShiftRows, MixColumns and AddRoundKey are written inline.
- The inverse-cipher block reuses aes_pkg.

## Test plan
- AES-128, keys from key 000102…0f, in=00112233445566778899aabbccddeeff, enable held → after 1 edge out=00102030405060708090a0b0c0d0e0f0; after 2 edges out=89d810e8855ace682d1843d8cb128fe4; after 11 edges out=69c4e0d86a7b0430d8cdb78070b4c55a.
- Continue enabling 5 more edges after the AES-128 result → out stays 69c4e0d8…c55a.
- Nr=12, key 000102…1617, same plaintext → after 13 edges out=dda97ca4864cdfe06eaf70a0ec0d7191.
- Nr=14, key 000102…1e1f, same plaintext → after 15 edges out=8ea2b7ca516745bfeafc49904b496089.
- Deassert enable for 3 cycles mid-run (AES-128) → out frozen during the pause; the final result arrives 3 cycles late and is unchanged.
- Pulse reset between clock edges at rc=6 → out=0 asynchronously. A fresh run then gives the correct ciphertext after 11 edges.
